// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: alignment/limit checks, req/ack bus
// handshake with timeout, byte-lane steering for stores and load extension.
module mem_access_unit #(
  parameter int unsigned TIMEOUT    = 15,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_7F2C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        valid_in,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        stall,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                         OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [3:0]  op_q;
  logic [1:0]  lo_q;

  logic        is_load, is_store, act, mis, bad, start, timeout, load_q;
  logic [3:0]  be_nxt;
  logic [31:0] wd_nxt, ext, half, byte_w;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign is_load  = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
  assign is_store = (mem_op >= OP_SW) && (mem_op <= OP_SB);
  assign act      = valid_in & (is_load | is_store);
  assign bad      = mis | (addr >= ADDR_LIMIT);
  assign start    = (state == S_IDLE) & act & ~bad & ~Req;
  assign timeout  = ~bus_ack & (cnt == 8'(TIMEOUT - 1));
  assign load_q   = (op_q >= OP_LW) && (op_q <= OP_LBU);

  always_comb begin
    mis    = 1'b0;
    be_nxt = 4'b0000;
    wd_nxt = '0;
    case (mem_op)
      OP_LW:         mis = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU: mis = addr[0];
      OP_SW: begin
        mis    = (addr[1:0] != 2'b00);
        be_nxt = 4'b1111;
        wd_nxt = wdata;
      end
      OP_SH: begin
        mis    = addr[0];
        be_nxt = addr[1] ? 4'b1100 : 4'b0011;
        wd_nxt = {2{wdata[15:0]}};
      end
      OP_SB: begin
        be_nxt = 4'b0001 << addr[1:0];
        wd_nxt = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection uses the address latched at request time, not the live addr.
  always_comb begin
    lane_h = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lo_q)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    half   = {16'h0000, lane_h};
    byte_w = {24'h000000, lane_b};
    case (op_q)
      OP_LW:   ext = bus_rdata;
      OP_LH:   ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ext = half;
      OP_LB:   ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ext = byte_w;
      default: ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    case (state)
      S_IDLE: begin
        stall    = act & ~bad;
        exc_adel = act & is_load & bad;
        exc_ades = act & is_store & bad;
        if (start) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (Req)          state_nxt = S_IDLE;
        else if (bus_ack) state_nxt = S_DONE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_byteen <= '0;
      bus_wdata  <= '0;
      rdata_out  <= '0;
      exc_bus    <= 1'b0;
      cnt        <= '0;
      op_q       <= '0;
      lo_q       <= '0;
    end else begin
      exc_bus <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bus_req    <= 1'b1;
            bus_we     <= is_store;
            bus_addr   <= {addr[31:2], 2'b00};
            bus_byteen <= be_nxt;
            bus_wdata  <= wd_nxt;
            op_q       <= mem_op;
            lo_q       <= addr[1:0];
            cnt        <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          // Flush outranks a same-cycle ack, which outranks the timeout.
          if (Req) begin
            bus_req <= 1'b0;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            if (load_q) rdata_out <= ext;
          end else if (timeout) begin
            bus_req <= 1'b0;
            exc_bus <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, corner-case
// sequences (flush, reset, timeout) and random accesses against a reference model.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 15;
  localparam logic [31:0] LIMIT   = 32'h0000_7F2C;

  logic        clk, reset, Req, valid_in, bus_ack;
  logic [3:0]  mem_op;
  logic [31:0] addr, wdata, bus_rdata;
  logic        bus_req, bus_we, done, stall, exc_adel, exc_ades, exc_bus;
  logic [31:0] bus_addr, bus_wdata, rdata_out;
  logic [3:0]  bus_byteen;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_rd = '0;

  mem_access_unit #(.TIMEOUT(TIMEOUT), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .Req(Req), .valid_in(valid_in), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .rdata_out(rdata_out),
    .done(done), .stall(stall), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .exc_bus(exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: plain arithmetic over the access rules.
  function automatic bit m_is_ld(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd5;
  endfunction
  function automatic bit m_is_st(input logic [3:0] op);
    return op >= 4'd6 && op <= 4'd8;
  endfunction
  function automatic bit m_bad(input logic [3:0] op, input logic [31:0] a);
    int unsigned align;
    align = (op == 4'd1 || op == 4'd6) ? 4 : (op == 4'd2 || op == 4'd3 || op == 4'd7) ? 2 : 1;
    return ((a % align) != 0) || (a >= LIMIT);
  endfunction
  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    case (op)
      4'd6:    return 4'hF;
      4'd7:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
      4'd8:    return 4'(1 << (a % 4));
      default: return 4'h0;
    endcase
  endfunction
  function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] wd);
    case (op)
      4'd7:    return (wd & 32'hFFFF) * 32'h0001_0001;
      4'd8:    return (wd & 32'hFF) * 32'h0101_0101;
      default: return wd;
    endcase
  endfunction
  function automatic logic [31:0] m_ld(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * (a % 4));
    case (op)
      4'd2:    return 32'($signed(s[15:0]));
      4'd3:    return s & 32'h0000_FFFF;
      4'd4:    return 32'($signed(s[7:0]));
      4'd5:    return s & 32'h0000_00FF;
      default: return rd;
    endcase
  endfunction

  // One access from IDLE; ackw = WAIT cycles without ack before the ack (>=TIMEOUT -> timeout).
  task automatic run_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input int ackw, input logic [31:0] rd, input bit e_adel, input bit e_ades,
                            input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_rd,
                            input bit req_done);
    bit ld, st, go;
    ld = m_is_ld(op);
    st = m_is_st(op);
    go = (ld || st) && !e_adel && !e_ades;
    valid_in = 1'b1; mem_op = op; addr = a; wdata = wd; Req = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    chk("exc_adel", exc_adel, e_adel);
    chk("exc_ades", exc_ades, e_ades);
    chk("stall_idle", stall, go);
    chk("bus_req_idle", bus_req, 0);
    @(posedge clk); #1;
    if (!go) begin
      valid_in = 1'b0; mem_op = 4'd0;
      @(negedge clk);
      chk("bus_req_noissue", bus_req, 0);
      @(posedge clk); #1;
      return;
    end
    for (int w = 0; w < int'(TIMEOUT); w++) begin
      if (w == ackw) begin bus_ack = 1'b1; bus_rdata = rd; end
      else bus_rdata = $urandom;
      @(negedge clk);
      chk("bus_req_wait", bus_req, 1);
      chk("stall_wait", stall, 1);
      chk("done_wait", done, 0);
      chk("bus_we", bus_we, st);
      chk("bus_addr", bus_addr, a & ~32'h3);
      chk("bus_byteen", bus_byteen, e_be);
      if (st) chk("bus_wdata", bus_wdata, e_wd);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (w == ackw) break;
    end
    valid_in = 1'b0; mem_op = 4'd0;
    if (ackw < int'(TIMEOUT)) begin
      if (ld) last_rd = e_rd;
      if (req_done) Req = 1'b1;
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("stall_done", stall, 0);
      chk("bus_req_done", bus_req, 0);
      chk("rdata_out", rdata_out, last_rd);
      @(posedge clk); #1;
      Req = 1'b0;
      @(negedge clk);
      chk("done_after", done, 0);
      chk("bus_req_after", bus_req, 0);
    end else begin
      @(negedge clk);
      chk("bus_req_timeout", bus_req, 0);
      chk("exc_bus_pulse", exc_bus, 1);
      chk("done_timeout", done, 0);
      chk("rdata_timeout", rdata_out, last_rd);
      @(posedge clk); #1;
      @(negedge clk);
      chk("exc_bus_after", exc_bus, 0);
      chk("bus_req_after_to", bus_req, 0);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    int          ackw;
    logic [31:0] rd;
    bit          adel;
    bit          ades;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{4'd1, 32'h100,  32'h0,        1, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{4'd4, 32'h103,  32'h0,        0, 32'h80FFFF7F, 0, 0, 4'h0, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{4'd5, 32'h103,  32'h0,        2, 32'h80FFFF7F, 0, 0, 4'h0, 32'h0,        32'h00000080};
    tbl[3]  = '{4'd7, 32'h202,  32'h1234ABCD, 0, 32'h0,        0, 0, 4'hC, 32'hABCDABCD, 32'h0};
    tbl[4]  = '{4'd1, 32'h101,  32'h0,        0, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0};
    tbl[5]  = '{4'd6, 32'h7F2C, 32'h0,        0, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0};
    tbl[6]  = '{4'd8, 32'h7F2B, 32'h0000005A, 1, 32'h0,        0, 0, 4'h8, 32'h5A5A5A5A, 32'h0};
    tbl[7]  = '{4'd2, 32'h102,  32'h0,        0, 32'h80011234, 0, 0, 4'h0, 32'h0,        32'hFFFF8001};
    tbl[8]  = '{4'd3, 32'h100,  32'h0,        1, 32'h8001F234, 0, 0, 4'h0, 32'h0,        32'h0000F234};
    tbl[9]  = '{4'd6, 32'h7F28, 32'h11223344, 3, 32'h0,        0, 0, 4'hF, 32'h11223344, 32'h0};
    tbl[10] = '{4'd3, 32'h101,  32'h0,        0, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0};
    tbl[11] = '{4'd9, 32'h0,    32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0};
    tbl[12] = '{4'd4, 32'h100,  32'h0,        0, 32'h000000FE, 0, 0, 4'h0, 32'h0,        32'hFFFFFFFE};
    tbl[13] = '{4'd8, 32'h101,  32'h000000AB, 0, 32'h0,        0, 0, 4'h2, 32'hABABABAB, 32'h0};

    reset = 1'b1; Req = 1'b0; valid_in = 1'b0; mem_op = '0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_byteen", bus_byteen, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_rdata_out", rdata_out, 0);
    chk("rst_done", done, 0);
    chk("rst_exc_bus", exc_bus, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (tbl[i])
      run_access(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].ackw, tbl[i].rd,
                 tbl[i].adel, tbl[i].ades, tbl[i].be, tbl[i].ewd, tbl[i].erd, 1'b0);

    // Timeout: no ack for TIMEOUT WAIT cycles.
    run_access(4'd1, 32'h300, 32'h0, TIMEOUT, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Flush in DONE: done still pulses and the loaded value is kept.
    run_access(4'd1, 32'h304, 32'h0, 0, 32'hCAFEF00D, 0, 0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1);

    // Flush in IDLE: no request issued.
    valid_in = 1'b1; mem_op = 4'd1; addr = 32'h10; Req = 1'b1;
    @(negedge clk);
    chk("req_idle_stall", stall, 1);
    @(posedge clk); #1;
    Req = 1'b0; valid_in = 1'b0; mem_op = 4'd0;
    @(negedge clk);
    chk("req_idle_bus_req", bus_req, 0);
    chk("req_idle_stall_after", stall, 0);
    @(posedge clk); #1;

    // Flush in WAIT together with an ack: ack ignored.
    valid_in = 1'b1; mem_op = 4'd1; addr = 32'h40;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_op = 4'd0; Req = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55;
    @(negedge clk);
    chk("req_wait_bus_req", bus_req, 1);
    @(posedge clk); #1;
    Req = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    chk("req_wait_drop", bus_req, 0);
    chk("req_wait_done", done, 0);
    chk("req_wait_rdata", rdata_out, last_rd);
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_wait_no_done", done, 0);
    @(posedge clk); #1;

    // Reset in the middle of a store's WAIT phase.
    valid_in = 1'b1; mem_op = 4'd6; addr = 32'h84; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_op = 4'd0;
    @(negedge clk);
    chk("midrst_pre_req", bus_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_bus_req", bus_req, 0);
    chk("midrst_bus_we", bus_we, 0);
    chk("midrst_bus_addr", bus_addr, 0);
    chk("midrst_byteen", bus_byteen, 0);
    chk("midrst_wdata", bus_wdata, 0);
    chk("midrst_rdata", rdata_out, 0);
    chk("midrst_done", done, 0);
    chk("midrst_stall", stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_rd = '0;

    // Random accesses against the model.
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  op;
      logic [31:0] a, wd, rd;
      int          ackw;
      bit          bd;
      op = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) a = LIMIT - 32'd8 + 32'($urandom_range(0, 15));
      else                           a = 32'($urandom_range(0, 32'h7FFF));
      wd = $urandom;
      rd = $urandom;
      ackw = ($urandom_range(0, 7) == 0) ? int'(TIMEOUT) + 1 : int'($urandom_range(0, 4));
      bd = m_bad(op, a);
      run_access(op, a, wd, ackw, rd, bd && m_is_ld(op), bd && m_is_st(op),
                 m_be(op, a), m_wd(op, wd), m_ld(op, a, rd), $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
